stack_queue_store: RTL
======================

// Module: stack_queue_store
// PURPOSE
//  Operand storage that answers the calculator's memory controller (responder side of push/pop requests).
//  Holds up to DEPTH words. Runs as a LIFO stack or a FIFO queue, selected by the debounced mode switch.
//  Returns popped data one cycle later and exposes the top two entries as ALU operands.
//  Drives the board's empty/full LEDs.
// PARAMETERS
//  DATA_W  32  word width (matches ALU operands and the 7-seg display value)
//  DEPTH   8   number of entries; power of two, >= 2
//  ADDR_W  $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
//  clk        in   1         system clock
//  rst        in   1         asynchronous reset, active-high
//  mode       in   1         1 = stack (LIFO), 0 = queue (FIFO); debounced level
//  push       in   1         single-cycle write request
//  pop        in   1         single-cycle read request
//  wr_data    in   DATA_W    data written on push
//  rd_data    out  DATA_W    popped word, registered
//  rd_valid   out  1         1-cycle pulse: rd_data updated
//  peek_a     out  DATA_W    stack: top; queue: head (0 if count<1)
//  peek_b     out  DATA_W    stack: below top; queue: head+1 (0 if count<2)
//  count      out  ADDR_W+1  current occupancy, 0..DEPTH
//  empty      out  1         count==0
//  full       out  1         count==DEPTH
//  overflow   out  1         1-cycle pulse: push dropped
//  underflow  out  1         1-cycle pulse: pop ignored
// BEHAVIOUR
//  Reset (async):
//   - count, head, tail, mode_q = 0/0/0/mode; rd_data = 0
//   - rd_valid, overflow, underflow = 0; empty = 1; full = 0
//   - storage array is not reset
//  Latency:
//   - Push is written at the clock edge; peek reflects it the next cycle.
//   - Pop: rd_data and rd_valid appear the cycle after pop is asserted.
//  Stack mode:
//   - push writes mem[count], count+1
//   - pop returns mem[count-1], count-1
//  Queue mode:
//   - push writes mem[tail], tail+1 mod DEPTH
//   - pop returns mem[head], head+1 mod DEPTH
//   - pointers wrap silently
//  push & pop in the same cycle with count>0:
//   - count is unchanged; both operations succeed, even when full
//   - stack: rd_data = old top; wr_data replaces top
//   - queue: rd_data = old head; wr_data goes to tail
//  push & pop in the same cycle with count==0:
//   - push succeeds
//   - pop is ignored and underflow pulses
//   - no rd_valid
//  Edge cases:
//   - push when full without pop: data dropped, state unchanged, overflow pulses
//   - pop when empty: rd_data holds its value, underflow pulses
//  Mode change (mode != mode_q):
//   - flush: count, head and tail go to 0 and mode_q takes the new mode
//   - push and pop in that cycle are ignored, with no pulses
//  peek_a/peek_b: combinational from the array and pointers; indices are computed mod DEPTH.
//  Width rule: count is ADDR_W+1 bits, so DEPTH itself is representable; pointers are ADDR_W bits.
// STRUCTURE
//  Package sq_pkg:
//   - DATA_W_DEF = 32, DEPTH_DEF = 8
//   - MODE_STACK = 1'b1, MODE_QUEUE = 1'b0
//  Sub-module sq_ram:
//   - DEPTH x DATA_W register array
//   - 1 synchronous write port, 3 asynchronous read ports (pop, peek_a, peek_b)
//  Top of this block: pointer/count control, mode tracking, output registers.
// TESTING
//  1. Reset, mode=1, push 5,7,9 -> count=3, peek_a=9, peek_b=7; pop -> next cycle rd_data=9, rd_valid=1, count=2.
//  2. mode=0, push 5,7,9; pop x3 -> rd_data 5,7,9 in order; then empty=1; 4th pop -> underflow pulse, rd_data stays 9.
//  3. Queue, DEPTH=8: push 1..8 -> full=1; 9th push -> overflow, count=8; pop 3, push 10,11,12 -> wrap, pops yield 4..8,10,11,12.
//  4. Stack with count=2 (top=7): push=pop=1, wr_data=3 -> rd_data=7, count=2, peek_a=3; same when full -> no overflow.
//  5. count=0, push=pop=1, wr_data=4 -> count=1, underflow pulse, rd_valid=0, peek_a=4.
//  6. count=4, toggle mode -> next cycle count=0, empty=1, no pulses; rst mid-sequence -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sq_pkg.sv
// sq_pkg: shared constants for the stack/queue operand store.
//   DATA_W_DEF / DEPTH_DEF : default word width and entry count
//   MODE_STACK / MODE_QUEUE: encodings of the debounced mode switch
package sq_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;

    localparam logic MODE_STACK = 1'b1;
    localparam logic MODE_QUEUE = 1'b0;

endpackage

// File: rtl/sq_ram.sv
// sq_ram: DEPTH x DATA_W register array for the operand store.
//   clk              : write clock
//   we/waddr/wdata   : synchronous write port
//   raddr_p/rdata_p  : asynchronous read port for pops
//   raddr_a/rdata_a  : asynchronous read port for peek_a
//   raddr_b/rdata_b  : asynchronous read port for peek_b
// Contents are deliberately not reset.
module sq_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_p,
    output logic [DATA_W-1:0] rdata_p,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_p = mem[raddr_p];
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/stack_queue_store.sv
// stack_queue_store: operand storage answering push/pop requests, run as a
// LIFO stack (mode=1) or FIFO queue (mode=0).
//   clk, rst          : clock, asynchronous active-high reset
//   mode              : debounced mode level; a change flushes the store
//   push, pop         : single-cycle requests, wr_data written on push
//   rd_data, rd_valid : popped word, registered, valid pulse one cycle later
//   peek_a, peek_b    : top/below-top (stack) or head/head+1 (queue), 0 if absent
//   count, empty, full: occupancy and LED flags
//   overflow          : pulse, push dropped because full
//   underflow         : pulse, pop ignored because empty
module stack_queue_store
    import sq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] peek_a,
    output logic [DATA_W-1:0] peek_b,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic              mode_q;
    logic [ADDR_W-1:0] head, tail;

    logic              flush;
    logic              do_pop, do_push;
    logic              is_stack;
    logic [ADDR_W-1:0] top_idx, below_idx, cnt_idx;
    logic [ADDR_W-1:0] waddr, raddr_p, raddr_a, raddr_b;
    logic [DATA_W-1:0] rdata_p, rdata_a, rdata_b;

    assign is_stack = (mode_q == MODE_STACK);
    assign flush    = (mode != mode_q);

    // A pop frees a slot in the same cycle, so push alongside pop is
    // accepted even when full.
    assign do_pop  = pop && !flush && (count != '0);
    assign do_push = push && !flush && ((count != FULL_CNT) || do_pop);

    // Stack indices wrap through the ADDR_W truncation (count==DEPTH -> 0).
    assign cnt_idx   = count[ADDR_W-1:0];
    assign top_idx   = cnt_idx - 1'b1;
    assign below_idx = cnt_idx - 2'd2;

    always_comb begin
        if (is_stack) begin
            // Simultaneous push+pop in stack mode replaces the top entry.
            waddr   = do_pop ? top_idx : cnt_idx;
            raddr_p = top_idx;
            raddr_a = top_idx;
            raddr_b = below_idx;
        end else begin
            waddr   = tail;
            raddr_p = head;
            raddr_a = head;
            raddr_b = head + 1'b1;
        end
    end

    sq_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we      (do_push),
        .waddr   (waddr),
        .wdata   (wr_data),
        .raddr_p (raddr_p),
        .rdata_p (rdata_p),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            mode_q    <= mode;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid  <= do_pop;
            overflow  <= push && !flush && !pop && (count == FULL_CNT);
            underflow <= pop && !flush && (count == '0);
            if (do_pop) rd_data <= rdata_p;

            if (flush) begin
                count  <= '0;
                head   <= '0;
                tail   <= '0;
                mode_q <= mode;
            end else begin
                count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
                if (!is_stack) begin
                    if (do_pop)  head <= head + 1'b1;
                    if (do_push) tail <= tail + 1'b1;
                end
            end
        end
    end

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign peek_a = (count >= CNT_W'(1)) ? rdata_a : '0;
    assign peek_b = (count >= CNT_W'(2)) ? rdata_b : '0;

endmodule
